// File: rtl/baseline_avg_mc.sv
`default_nettype none
// ============================================================================
// baseline_avg_mc : per-channel 2^L block-average baseline with pulse veto,
//                   plus saturated baseline-subtracted sample stream.
// Revision: 1.0
// ============================================================================
module baseline_avg_mc #(
    parameter int W        = 16,
    parameter int NCH      = 5,
    parameter int MAX_LOG2 = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [NCH*W-1:0] din,
    input  logic             din_valid,
    input  logic [4:0]       log2_win,
    input  logic             veto_en,
    input  logic [W-1:0]     veto_thr,
    output logic [NCH*W-1:0] baseline,
    output logic             baseline_valid,
    output logic [NCH-1:0]   window_rejected,
    output logic [NCH*W-1:0] dout,
    output logic             dout_valid
);

    localparam int         ACC_W   = W + MAX_LOG2;
    localparam int         CNT_W   = MAX_LOG2 + 1;
    localparam logic [4:0] C_MAX_L = 5'(MAX_LOG2);

    typedef enum logic [1:0] {
        S_PRIME  = 2'd0,
        S_ACCUM  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NCH*W-1:0]   r_din;
    logic               r_vld;
    logic               r_en;
    logic [4:0]         r_l;
    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         w_l_new;
    logic [CNT_W-1:0]   w_lim;
    logic [CNT_W-1:0]   w_lim_new;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_upd;
    logic               w_acc;
    logic               w_veto_act;

    assign w_l_new    = (log2_win > C_MAX_L) ? C_MAX_L : log2_win;
    assign w_lim      = CNT_W'(1) << r_l;
    assign w_lim_new  = CNT_W'(1) << w_l_new;
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_upd      = (r_state == S_UPDATE);
    assign w_acc      = r_vld && !w_upd;
    // The priming window has no baseline to compare against, so veto stays off.
    assign w_veto_act = veto_en && (r_state != S_PRIME);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_PRIME, S_ACCUM: begin
                if (r_vld && (w_cnt_inc == w_lim)) begin
                    w_state_nxt = S_UPDATE;
                end
            end
            // A sample landing in UPDATE opens the next window; with a
            // 1-sample window it also closes it immediately.
            S_UPDATE: begin
                w_state_nxt = (r_vld && (w_lim_new == CNT_W'(1))) ? S_UPDATE : S_ACCUM;
            end
            default: w_state_nxt = S_PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_PRIME;
            r_din          <= '0;
            r_vld          <= 1'b0;
            r_en           <= 1'b0;
            r_l            <= w_l_new;
            r_cnt          <= '0;
            baseline_valid <= 1'b0;
            dout_valid     <= 1'b0;
        end else begin
            r_din          <= din;
            r_vld          <= din_valid;
            r_en           <= enable;
            r_state        <= w_state_nxt;
            baseline_valid <= w_upd;
            dout_valid     <= r_vld;
            if (w_upd) begin
                r_l   <= w_l_new;
                r_cnt <= r_vld ? CNT_W'(1) : '0;
            end else if (r_vld) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [W-1:0]     w_x;
        logic [ACC_W-1:0] w_x_ext;
        logic [W:0]       w_diff;
        logic [W:0]       w_abs;
        logic             w_hit;
        logic [W-1:0]     w_avg;
        logic [W-1:0]     w_sat;
        logic [W-1:0]     r_bl;
        logic [ACC_W-1:0] r_acc;
        logic             r_flag;
        logic             r_rej;
        logic [W-1:0]     r_dout;

        assign w_x     = r_din[c*W +: W];
        assign w_x_ext = {{MAX_LOG2{w_x[W-1]}}, w_x};
        // One W+1 bit difference serves both the veto magnitude and dout.
        assign w_diff  = {w_x[W-1], w_x} - {r_bl[W-1], r_bl};
        assign w_abs   = w_diff[W] ? (~w_diff + 1'b1) : w_diff;
        assign w_hit   = w_veto_act && (w_abs > {1'b0, veto_thr});
        assign w_avg   = W'($signed(r_acc) >>> r_l);

        always_comb begin
            w_sat = w_diff[W-1:0];
            if (w_diff[W] != w_diff[W-1]) begin
                w_sat = w_diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_acc  <= '0;
                r_flag <= 1'b0;
                r_bl   <= '0;
                r_rej  <= 1'b0;
                r_dout <= '0;
            end else begin
                if (w_upd) begin
                    if (!r_flag) begin
                        r_bl <= w_avg;
                    end
                    r_rej  <= r_flag;
                    r_acc  <= r_vld ? w_x_ext : '0;
                    r_flag <= r_vld && w_hit;
                end else if (w_acc) begin
                    r_acc  <= r_acc + w_x_ext;
                    r_flag <= r_flag || w_hit;
                end
                r_dout <= r_en ? w_sat : '0;
            end
        end

        assign baseline[c*W +: W] = r_bl;
        assign dout[c*W +: W]     = r_dout;
        assign window_rejected[c] = r_rej;
    end

endmodule
`default_nettype wire
